// File: rtl/mips_cpu_pkg.sv
// Shared constants for the single-cycle MIPS core:
// opcode/funct encodings, reset vector and byte-lane helper.
package mips_cpu_pkg;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC0_0000;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Bus words travel with byte lanes reversed.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/mips_cpu_data_memory.sv
// Word-addressed data RAM: combinational read, write on rising edge.
// Contents are stored exactly as they appear on the bus.
module mips_cpu_data_memory #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic        clk,
    input  logic        clk_enable,
    input  logic [31:0] address,
    input  logic [31:0] writedata,
    input  logic        write,
    input  logic        read,
    input  logic        reset,
    output logic [31:0] readdata
);

    logic [31:0]           mem_q [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] idx;
    logic                  unused_addr_bits;

    assign idx = address[DEPTH_LOG2+1:2];
    assign unused_addr_bits = ^{address[31:DEPTH_LOG2+2], address[1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2**DEPTH_LOG2; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clk_enable && write) begin
            mem_q[idx] <= writedata;
        end
    end

    assign readdata = read ? mem_q[idx] : '0;

endmodule

// File: rtl/mips_cpu_regfile.sv
// 32x32 GPR file: two combinational reads, one synchronous write,
// asynchronous clear; $0 is hardwired to zero.
module mips_cpu_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_a_i,
    input  logic [4:0]  raddr_b_i,
    output logic [31:0] rdata_a_o,
    output logic [31:0] rdata_b_o,
    output logic [31:0] v0_o
);

    logic [31:0] regs_q [32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == 5'd0) ? '0 : regs_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == 5'd0) ? '0 : regs_q[raddr_b_i];
    assign v0_o      = regs_q[2];

endmodule

// File: rtl/mips_cpu_harvard.sv
// Single-cycle MIPS-I subset, Harvard buses, one branch delay slot,
// halts when the PC reaches HALT_ADDR.
module mips_cpu_harvard
    import mips_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [31:0] HALT_ADDR    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    input  logic        clk_enable,
    output logic [31:0] instr_address,
    input  logic [31:0] instr_readdata,
    output logic [31:0] data_address,
    output logic        data_write,
    output logic        data_read,
    output logic [31:0] data_writedata,
    input  logic [31:0] data_readdata
);

    logic [31:0] pc_q, pc_d, npc_q, npc_d;
    logic        active_q, active_d;
    logic [31:0] instr;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] rs_val, rt_val, imm_s, imm_z, pc4, link;
    logic        we, is_lw, is_sw, run;
    logic [4:0]  wa;
    logic [31:0] wd;

    assign instr = bswap32(instr_readdata);
    assign {op, rs, rt, rd, sh, fn} = instr;
    assign imm   = instr[15:0];
    assign tgt   = instr[25:0];
    assign imm_s = {{16{imm[15]}}, imm};
    assign imm_z = {16'h0000, imm};
    assign pc4   = pc_q + 32'd4;
    assign link  = pc_q + 32'd8;
    assign run   = active_q && clk_enable;

    mips_cpu_regfile u_regfile (
        .clk       (clk),
        .rst_n     (reset),
        .we_i      (run && we),
        .waddr_i   (wa),
        .wdata_i   (wd),
        .raddr_a_i (rs),
        .raddr_b_i (rt),
        .rdata_a_o (rs_val),
        .rdata_b_o (rt_val),
        .v0_o      (register_v0)
    );

    always_comb begin
        npc_d = npc_q + 32'd4;
        we    = 1'b0;
        wa    = rt;
        wd    = '0;
        is_lw = 1'b0;
        is_sw = 1'b0;
        case (op)
            OP_SPECIAL: begin
                wa = rd;
                we = 1'b1;
                case (fn)
                    FN_ADDU: wd = rs_val + rt_val;
                    FN_SUBU: wd = rs_val - rt_val;
                    FN_AND:  wd = rs_val & rt_val;
                    FN_OR:   wd = rs_val | rt_val;
                    FN_XOR:  wd = rs_val ^ rt_val;
                    FN_SLT:  wd = {31'd0, $signed(rs_val) < $signed(rt_val)};
                    FN_SLTU: wd = {31'd0, rs_val < rt_val};
                    FN_SLL:  wd = rt_val << sh;
                    FN_SRL:  wd = rt_val >> sh;
                    FN_JR: begin
                        we    = 1'b0;
                        npc_d = rs_val;
                    end
                    FN_JALR: begin
                        wd    = link;
                        npc_d = rs_val;
                    end
                    default: we = 1'b0;
                endcase
            end
            OP_J:   npc_d = {pc4[31:28], tgt, 2'b00};
            OP_JAL: begin
                npc_d = {pc4[31:28], tgt, 2'b00};
                we    = 1'b1;
                wa    = 5'd31;
                wd    = link;
            end
            OP_BEQ: if (rs_val == rt_val) npc_d = pc4 + (imm_s << 2);
            OP_BNE: if (rs_val != rt_val) npc_d = pc4 + (imm_s << 2);
            OP_ADDIU: begin we = 1'b1; wd = rs_val + imm_s; end
            OP_SLTI: begin
                we = 1'b1;
                wd = {31'd0, $signed(rs_val) < $signed(imm_s)};
            end
            OP_SLTIU: begin we = 1'b1; wd = {31'd0, rs_val < imm_s}; end
            OP_ANDI:  begin we = 1'b1; wd = rs_val & imm_z; end
            OP_ORI:   begin we = 1'b1; wd = rs_val | imm_z; end
            OP_XORI:  begin we = 1'b1; wd = rs_val ^ imm_z; end
            OP_LUI:   begin we = 1'b1; wd = {imm, 16'h0000}; end
            OP_LW: begin
                we    = 1'b1;
                is_lw = 1'b1;
                wd    = bswap32(data_readdata);
            end
            OP_SW:   is_sw = 1'b1;
            default: ;
        endcase
        // The delay slot is always the instruction already queued in npc_q.
        pc_d     = npc_q;
        active_d = (npc_q != HALT_ADDR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= RESET_VECTOR;
            npc_q    <= RESET_VECTOR + 32'd4;
            active_q <= 1'b1;
        end else if (run) begin
            pc_q     <= pc_d;
            npc_q    <= npc_d;
            active_q <= active_d;
        end
    end

    assign active         = active_q;
    assign instr_address  = pc_q;
    assign data_address   = rs_val + imm_s;
    assign data_read      = run && is_lw;
    assign data_write     = run && is_sw;
    assign data_writedata = bswap32(rt_val);

endmodule

// File: tb/tb_mips_cpu_harvard.sv
// Directed program table plus reset and clock-enable sequences
// for the single-cycle MIPS core.
module tb_mips_cpu_harvard;

    localparam logic [31:0] RV  = 32'hBFC0_0000;
    localparam logic [31:0] JR0 = 32'h0000_0008;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce = 1'b1;
    logic        active;
    logic [31:0] register_v0, instr_address, instr_readdata;
    logic [31:0] data_address, data_writedata, data_readdata;
    logic        data_write, data_read;

    logic [31:0] imem [16];
    logic [31:0] off;

    int n_tests = 0;
    int n_fail = 0;
    int wr_cnt, rd_cnt, cyc;
    logic [31:0] last_waddr, last_wdata;

    typedef struct {
        string             name;
        logic [7:0][31:0]  prog;
        logic [31:0]       exp_v0;
        int                exp_cyc;
        int                exp_wr;
        int                exp_rd;
    } vec_t;

    vec_t vecs[13];

    always #5 clk = ~clk;

    mips_cpu_harvard dut (
        .clk            (clk),
        .reset          (rst_n),
        .active         (active),
        .register_v0    (register_v0),
        .clk_enable     (ce),
        .instr_address  (instr_address),
        .instr_readdata (instr_readdata),
        .data_address   (data_address),
        .data_write     (data_write),
        .data_read      (data_read),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata)
    );

    mips_cpu_data_memory u_mem (
        .clk        (clk),
        .clk_enable (ce),
        .address    (data_address),
        .writedata  (data_writedata),
        .write      (data_write),
        .read       (data_read),
        .reset      (rst_n),
        .readdata   (data_readdata)
    );

    function automatic logic [31:0] sw32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    always_comb begin
        off = instr_address - RV;
        if (off[31:6] == 26'd0) instr_readdata = sw32(imem[off[5:2]]);
        else instr_readdata = 32'h0;
    end

    always @(negedge clk) begin
        if (data_write) begin
            wr_cnt++;
            last_waddr = data_address;
            last_wdata = data_writedata;
        end
        if (data_read) rd_cnt++;
    end

    function automatic logic [31:0] ii(int op, int rs, int rt, int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    function automatic logic [31:0] rr(int rs, int rt, int rd, int sh, int fn);
        return {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
    endfunction

    function automatic logic [31:0] jj(int op, int t);
        return {op[5:0], t[25:0]};
    endfunction

    function automatic logic [7:0][31:0] P(
        input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
        logic [7:0][31:0] p;
        p[0] = a0; p[1] = a1; p[2] = a2; p[3] = a3;
        p[4] = a4; p[5] = a5; p[6] = a6; p[7] = a7;
        return p;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic start(input logic [7:0][31:0] p);
        @(negedge clk);
        rst_n = 1'b0;
        ce = 1'b1;
        for (int i = 0; i < 16; i++) imem[i] = (i < 8) ? p[i] : 32'h0;
        wr_cnt = 0;
        rd_cnt = 0;
        cyc = 0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_to_halt(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!active) break;
        end
    endtask

    task automatic run_pause(input string nm, input logic [7:0][31:0] p,
                             input logic [31:0] mid_v0,
                             input logic [31:0] end_v0,
                             input int exp_wr, input int exp_cyc);
        start(p);
        run_to_halt(1);
        @(negedge clk);
        ce = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check({nm, "_pause_pc"}, instr_address, RV + 32'd4);
        check({nm, "_pause_v0"}, register_v0, mid_v0);
        check({nm, "_pause_active"}, {31'd0, active}, 32'd1);
        @(negedge clk);
        ce = 1'b1;
        run_to_halt(40);
        check({nm, "_v0"}, register_v0, end_v0);
        check({nm, "_cycles"}, cyc, exp_cyc);
        check({nm, "_writes"}, wr_cnt, exp_wr);
    endtask

    initial begin
        vecs[0] = '{"addiu_delay", P(ii(9,2,2,1), JR0, ii(9,2,2,1),
                    0, 0, 0, 0, 0), 32'd2, 3, 0, 0};
        vecs[1] = '{"lui_ori", P(ii(15,0,2,'h1234), ii(13,2,2,'h5678),
                    JR0, 0, 0, 0, 0, 0), 32'h1234_5678, 4, 0, 0};
        vecs[2] = '{"sw_lw", P(ii(9,0,3,'h55), ii('h2B,0,3,16),
                    ii('h23,0,2,16), JR0, 0, 0, 0, 0), 32'h55, 5, 1, 1};
        vecs[3] = '{"beq_taken", P(ii(4,0,0,2), ii(9,2,2,1), ii(9,2,2,1),
                    JR0, 0, 0, 0, 0), 32'd1, 4, 0, 0};
        vecs[4] = '{"slt_sltu", P(ii(9,0,3,-1), rr(0,3,2,0,'h2B),
                    rr(3,0,4,0,'h2A), rr(2,4,2,0,'h21), JR0, 0, 0, 0),
                    32'd2, 6, 0, 0};
        vecs[5] = '{"zero_badop", P(ii(9,0,0,5), 32'hFC42_FFFF,
                    ii(9,0,2,7), JR0, 0, 0, 0, 0), 32'd7, 5, 0, 0};
        vecs[6] = '{"andi_zext", P(ii(9,0,3,-1), ii(12,3,2,'h8000), JR0,
                    0, 0, 0, 0, 0), 32'h8000, 4, 0, 0};
        vecs[7] = '{"sll_srl", P(ii(9,0,3,1), rr(0,3,2,31,0),
                    rr(0,2,2,4,2), JR0, 0, 0, 0, 0), 32'h0800_0000, 5, 0, 0};
        vecs[8] = '{"jal_link", P(jj(3,'h03F0_0004), 0, ii(9,2,2,100), 0,
                    rr(31,0,2,0,'h21), JR0, 0, 0), 32'hBFC0_0008, 5, 0, 0};
        vecs[9] = '{"xori_bne_nt", P(ii(9,0,2,'h0F0F), ii(14,2,2,'hFFFF),
                    ii(5,0,0,5), 0, JR0, 0, 0, 0), 32'h0000_F0F0, 6, 0, 0};
        vecs[10] = '{"jalr_link", P(ii(15,0,5,'hBFC0), ii(13,5,5,'h18),
                     rr(5,0,2,0,9), 0, ii(9,0,2,0), 0, JR0, 0),
                     32'hBFC0_0010, 6, 0, 0};
        vecs[11] = '{"subu_slti_bne", P(ii(9,0,3,5), rr(0,3,2,0,'h23),
                     ii(10,2,4,-4), ii(5,4,0,2), rr(2,4,2,0,'h21),
                     ii(9,0,2,0), JR0, 0), 32'hFFFF_FFFC, 7, 0, 0};
        vecs[12] = '{"and_or_xor", P(ii(9,0,3,'h0FF0), ii(13,0,4,'h3C3C),
                     rr(3,4,5,0,'h24), rr(3,4,6,0,'h26), rr(5,6,2,0,'h25),
                     JR0, 0, 0), 32'h0000_3FFC, 7, 0, 0};

        // Reset state, observed while reset is held.
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) imem[i] = 32'h0;
        #1;
        check("rst_pc", instr_address, RV);
        check("rst_v0", register_v0, 32'h0);
        check("rst_active", {31'd0, active}, 32'd1);
        check("rst_strobes", {30'd0, data_read, data_write}, 32'd0);

        for (int v = 0; v < 13; v++) begin
            start(vecs[v].prog);
            run_to_halt(40);
            check({vecs[v].name, "_v0"}, register_v0, vecs[v].exp_v0);
            check({vecs[v].name, "_cycles"}, cyc, vecs[v].exp_cyc);
            check({vecs[v].name, "_active"}, {31'd0, active}, 32'd0);
            check({vecs[v].name, "_pc"}, instr_address, 32'h0);
            check({vecs[v].name, "_writes"}, wr_cnt, vecs[v].exp_wr);
            check({vecs[v].name, "_reads"}, rd_cnt, vecs[v].exp_rd);
            if (vecs[v].exp_wr > 0) begin
                check({vecs[v].name, "_waddr"}, last_waddr, 32'h10);
                check({vecs[v].name, "_wdata"}, last_wdata, 32'h5500_0000);
            end
            repeat (2) @(posedge clk);
            #1;
            check({vecs[v].name, "_hold_v0"}, register_v0, vecs[v].exp_v0);
            check({vecs[v].name, "_hold_pc"}, instr_address, 32'h0);
            check({vecs[v].name, "_hold_active"}, {31'd0, active}, 32'd0);
        end

        // Loop program; reset lands while J's delay slot is pending.
        start(P(ii(9,2,2,1), jj(2,'h03F0_0000), 0, 0, 0, 0, 0, 0));
        run_to_halt(5);
        check("loop_pc", instr_address, RV + 32'd8);
        check("loop_v0", register_v0, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pc", instr_address, RV);
        check("async_rst_v0", register_v0, 32'h0);
        check("async_rst_active", {31'd0, active}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_pc", instr_address, RV + 32'd4);
        check("post_rst_v0", register_v0, 32'd1);

        run_pause("ce_lui", vecs[1].prog, 32'h1234_0000,
                  32'h1234_5678, 0, 4);
        run_pause("ce_sw", vecs[2].prog, 32'h0, 32'h55, 1, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_cpu_harvard.md
MIPS_CPU_HARVARD -- requirements
Module: mips_cpu_harvard

Interface
REQ-001 The block SHALL have parameter RESET_VECTOR, default 32'hBFC00000: first fetch address after reset.
REQ-002 The block SHALL have parameter HALT_ADDR, default 32'h00000000: a PC equal to this address stops the CPU.
REQ-003 Port clk, input, 1: single clock, rising-edge active.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port active, output, 1: high while executing, low once halted.
REQ-006 Port register_v0, output, 32: live value of GPR $2.
REQ-007 Port clk_enable, input, 1: when low, all state SHALL hold.
REQ-008 Port instr_address, output, 32: current PC, combinational.
REQ-009 Port instr_readdata, input, 32: instruction word with byte lanes reversed ([7:0] = most-significant byte); the core SHALL un-swap it internally.
REQ-010 Port data_address, output, 32: byte address for LW/SW.
REQ-011 Port data_write, output, 1: write strobe.
REQ-012 Port data_read, output, 1: read strobe.
REQ-013 Port data_writedata, output, 32: store data, byte lanes reversed as in REQ-009.
REQ-014 Port data_readdata, input, 32: load data, byte lanes reversed, valid combinationally in the same cycle.

Function
REQ-015 The CPU SHALL be single-cycle: one instruction per enabled rising edge; instr_readdata is valid combinationally from instr_address.
REQ-016 Supported instructions: ADDU SUBU AND OR XOR SLT SLTU SLL SRL JR JALR ADDIU ANDI ORI XORI SLTI SLTIU LUI LW SW BEQ BNE J JAL; every other encoding SHALL execute as NOP.
REQ-017 ADDIU/SLTI/SLTIU/LW/SW/branch offsets SHALL sign-extend imm16; ANDI/ORI/XORI SHALL zero-extend; all adds SHALL wrap modulo 2^32 with no overflow trap.
REQ-018 Writes to $0 SHALL be discarded; $0 SHALL always read 0.
REQ-019 Branches and jumps SHALL have one delay slot: the instruction at PC+4 always executes, then the PC SHALL take the target.
REQ-020 Branch target = (delay-slot address) + (sign-extended imm16 << 2).
REQ-021 J/JAL target = {delay-slot address[31:28], imm26, 2'b00}.
REQ-022 JAL SHALL write PC+8 to $31; JALR SHALL write PC+8 to rd.
REQ-023 LW SHALL drive data_read=1 and write the un-swapped data_readdata to rt on the same edge.
REQ-024 SW SHALL drive data_write=1 and data_writedata = swapped rt; data_read/data_write SHALL be 0 on all other instructions and while halted.
REQ-025 When the PC updates to HALT_ADDR, active SHALL drop to 0 on that edge, and the PC, register file and strobes SHALL freeze thereafter.
REQ-026 instr_address SHALL read HALT_ADDR while halted.
REQ-027 Simultaneous halt and register write: the write from the delay-slot instruction completing on that edge SHALL be committed.
REQ-028 With clk_enable=0, no PC, register or memory strobe effect SHALL occur, and outputs SHALL remain combinationally consistent with the held state.

Reset
REQ-029 While reset=0: PC=RESET_VECTOR, all GPRs=0, delay-slot state cleared, active=1, register_v0=0, data_read=data_write=0.
REQ-030 Reset SHALL take effect asynchronously and SHALL abort any pending branch, including mid-delay-slot.
REQ-031 After reset deasserts, the first fetch SHALL be RESET_VECTOR.

Structure
REQ-032 Opcode, funct and RESET_VECTOR constants SHALL reside in a shared package mips_cpu_pkg.
REQ-033 The register file SHALL be one sub-module, mips_cpu_regfile: 32x32, two combinational read ports, one synchronous write port, asynchronous active-low clear.
REQ-034 The companion block mips_cpu_data_memory (clk, clk_enable, address, writedata, write, read, reset, readdata) SHALL provide a combinational read and a write on the rising clock edge.

Verification
REQ-035 Fetch from 0xBFC00000: ADDIU $2,$2,1; JR $0; ADDIU $2,$2,1 -> the delay slot executes, the PC reaches 0, active=0, register_v0=2.
REQ-036 LUI $2,0x1234; ORI $2,$2,0x5678; JR $0; NOP -> register_v0=0x12345678 at halt.
REQ-037 ADDIU $3,$0,0x55; SW $3,16($0); LW $2,16($0); JR $0; NOP -> data_write pulses once at address 0x10, register_v0=0x55.
REQ-038 BEQ $0,$0,+2 with ADDIU $2,$2,1 in the delay slot, one skipped ADDIU, then JR $0 -> register_v0=1.
REQ-039 Assert reset mid-program -> PC returns to 0xBFC00000 immediately, register_v0=0, active=1.
REQ-040 Hold clk_enable=0 for 5 cycles mid-program -> instr_address and register_v0 unchanged; the final result is identical to the uninterrupted run.
